// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-iteration shift-add multiplier and restoring divider.
// A request is accepted in IDLE; the result appears 33 cycles later with a one-cycle done pulse.
`timescale 1ns/1ps
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic [31:0] op_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic        we_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  logic        sign_a_s;
  logic        sign_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic        neg_s;

  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic        div_ge_s;
  logic [31:0] div_sub_s;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  logic [63:0] prod_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] final_s;

  // Operand signedness, magnitudes and result sign at acceptance
  always_comb begin
    sign_a_s = 1'b0;
    sign_b_s = 1'b0;
    case (funct3)
      3'b000, 3'b001: begin
        sign_a_s = op_a[31];
        sign_b_s = op_b[31];
      end
      3'b010: begin
        sign_a_s = op_a[31];
        sign_b_s = 1'b0;
      end
      3'b100, 3'b110: begin
        sign_a_s = op_a[31];
        sign_b_s = op_b[31];
      end
      default: begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
      end
    endcase
    mag_a_s = sign_a_s ? (32'd0 - op_a) : op_a;
    mag_b_s = sign_b_s ? (32'd0 - op_b) : op_b;
    // Divide by zero keeps the all-ones quotient unsigned; remainders follow the dividend
    if (!funct3[2]) begin
      neg_s = sign_a_s ^ sign_b_s;
    end else if (funct3[1]) begin
      neg_s = sign_a_s;
    end else begin
      neg_s = (sign_a_s ^ sign_b_s) & (op_b != 32'd0);
    end
  end

  // One multiply or divide iteration on the magnitude accumulators
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : 33'd0);
    div_shift_s = {hi_q, lo_q[31]};
    div_ge_s    = (div_shift_s >= {1'b0, op_q});
    div_sub_s   = div_shift_s[31:0] - op_q;
    if (f3_q[2]) begin
      hi_d = div_ge_s ? div_sub_s : div_shift_s[31:0];
      lo_d = {lo_q[30:0], div_ge_s};
    end else begin
      hi_d = mul_sum_s[32:1];
      lo_d = {mul_sum_s[0], lo_q[31:1]};
    end
  end

  // Sign fix-up and result selection used at DONE
  always_comb begin
    prod_s     = {hi_q, lo_q};
    prod_fix_s = neg_q ? (64'd0 - prod_s) : prod_s;
    quo_fix_s  = neg_q ? (32'd0 - lo_q) : lo_q;
    rem_fix_s  = neg_q ? (32'd0 - hi_q) : hi_q;
    case (f3_q)
      3'b000:                 final_s = prod_fix_s[31:0];
      3'b001, 3'b010, 3'b011: final_s = prod_fix_s[63:32];
      3'b100, 3'b101:         final_s = quo_fix_s;
      3'b110, 3'b111:         final_s = rem_fix_s;
      default:                final_s = 32'd0;
    endcase
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      f3_q     <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      op_q     <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= 5'd0;
            f3_q    <= funct3;
            rd_q    <= rd_in;
            neg_q   <= neg_s;
            hi_q    <= 32'd0;
            if (funct3[2]) begin
              op_q <= mag_b_s;
              lo_q <= mag_a_s;
            end else begin
              op_q <= mag_a_s;
              lo_q <= mag_b_s;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          done_q   <= 1'b1;
          we_q     <= (rd_q != 5'd0);
          result_q <= final_s;
          rd_out_q <= rd_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign we_out = we_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low (`clk`, `rst`).
REQ-003 clk  input  1  the single rising-edge clock for all state.
REQ-004 rst  input  1  async active-low reset; 0 forces reset state immediately.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  input  32  rs1 value from the register file RD1 port.
REQ-008 op_b  input  32  rs2 value from the register file RD2 port.
REQ-009 rd_in  input  5  destination register index.
REQ-010 busy  output  1  high while an operation is in flight (RUN or DONE).
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  32  operation result for the register file WD3 port.
REQ-013 rd_out  output  5  latched destination index, drives the register file A3 port.
REQ-014 we_out  output  1  write enable for the register file WE3 port.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; busy = (state != IDLE).
REQ-016 IDLE with start=1 at an edge: latch funct3, rd_in, operand magnitudes and result sign; clear the 5-bit iteration counter; go to RUN.
REQ-017 IDLE with start=0: remain in IDLE; done=0, we_out=0.
REQ-018 RUN: one shift-add (multiply) or restoring shift-subtract (divide) iteration per edge, counter+1.
REQ-019 RUN: after the 32nd iteration (counter==31), go to DONE.
REQ-020 DONE: assert done=1 for exactly one cycle; result and rd_out valid; next state is IDLE.
REQ-021 Latency: start sampled at edge N gives done=1 in the cycle following edge N+33, i.e. 33 cycles after acceptance, for every funct3 including special cases.
REQ-022 we_out SHALL equal done AND (rd_out != 0).
REQ-023 start asserted in RUN or DONE SHALL be ignored; the next request is accepted at the first edge in IDLE.
REQ-024 Operand inputs SHALL NOT be sampled after the start edge; changes during RUN SHALL have no effect.
REQ-025 Signedness: MUL and MULH treat a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU, DIVU and REMU treat both as unsigned; DIV and REM treat both as signed.
REQ-026 Signed ops SHALL compute on magnitudes and two's-complement-negate at DONE.
REQ-027 Sign of a signed product or quotient = sign_a XOR sign_b; sign of a signed remainder = sign_a.
REQ-028 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the full 64-bit product.
REQ-029 Divide by zero: quotient = 0xFFFFFFFF for DIV and DIVU; remainder = op_a for REM and REMU; no exception.
REQ-030 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV or REM): quotient 0x80000000, remainder 0.
REQ-031 result and rd_out SHALL hold their last DONE values until the next DONE.

Reset
REQ-032 rst=0 SHALL force state IDLE, counter 0, busy=0, done=0, we_out=0, result=0, rd_out=0, all internal accumulators 0, asynchronously.
REQ-033 Reset mid-RUN SHALL abort the operation with no done or we_out pulse.
REQ-034 After rst returns high, start is accepted at the first rising edge.

Verification
REQ-035 MUL 6 x 7, rd_in=5 -> done exactly 33 cycles after acceptance, result=0x0000002A, rd_out=5, we_out=1 for one cycle.
REQ-036 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-038 DIV 7 / 0 -> 0xFFFFFFFF; REM 7 / 0 -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-039 Hold start=1 continuously; change op_a, op_b and funct3 during RUN -> results match the latched operands only; back-to-back ops complete 34 cycles apart; rd_in=0 -> done=1, we_out=0.
REQ-040 Pull rst=0 at iteration 10 -> busy, done, we_out and result drop to 0 immediately; no done pulse; a fresh MUL 3 x 3 after release -> 9.
